level_to_pulse: RTL and testbench

//  Converts a slow, asynchronous, bouncy level (DE1-SoC KEY push-button) into a single-cycle

---
 rtl/level_to_pulse_pkg.sv | 16 +
 rtl/level_to_pulse_sync_ff.sv | 24 ++
 rtl/level_to_pulse.sv | 84 ++++++++
 tb/tb_level_to_pulse.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/level_to_pulse_pkg.sv
// Shared constants and helpers for the level_to_pulse push-button conditioner.
package level_to_pulse_pkg;

  localparam int unsigned EDGE_PRESS   = 0;
  localparam int unsigned EDGE_RELEASE = 1;
  localparam int unsigned EDGE_BOTH    = 2;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles == 0) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/level_to_pulse_sync_ff.sv
// N-stage synchronizer for an asynchronous single-bit input, with a reset load value.
module level_to_pulse_sync_ff #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {N{RST_VAL}};
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/level_to_pulse.sv
// Synchronizes, debounces and polarity-normalizes a raw button level, then emits
// a one-cycle strobe on the selected edge(s).
module level_to_pulse
  import level_to_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned EDGE_MODE       = EDGE_PRESS
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic pulse,
  output logic level
);

  localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic           INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             synced;
  logic             state;
  logic             state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             prev;
  logic             pulse_nxt;
  logic             rise;
  logic             fall;

  level_to_pulse_sync_ff #(
    .N       (SYNC_STAGES),
    .RST_VAL (INACTIVE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (lvl),
    .q   (synced)
  );

  // Accept a new raw value only after it has differed from state long enough.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    if (synced != state) begin
      if (cnt == CNT_MAX) begin
        state_nxt = synced;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign level = state ^ INACTIVE;
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  always_comb begin
    pulse_nxt = 1'b0;
    if (EDGE_MODE == EDGE_PRESS) begin
      pulse_nxt = rise;
    end else if (EDGE_MODE == EDGE_RELEASE) begin
      pulse_nxt = fall;
    end else begin
      pulse_nxt = rise | fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INACTIVE;
      cnt   <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= level;
      pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_level_to_pulse.sv
// Bench for level_to_pulse: three parameterizations checked against a behavioural
// model every cycle, plus hand-computed timing expectations.
module tb_level_to_pulse;

  logic clk = 1'b0;
  logic rst;
  logic lvl_a;
  logic lvl_b;
  logic pulse0, level0, pulse2, level2, pulse6, level6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  level_to_pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .EDGE_MODE(0)) u0 (
    .clk(clk), .rst(rst), .lvl(lvl_a), .pulse(pulse0), .level(level0));
  level_to_pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .EDGE_MODE(2)) u2 (
    .clk(clk), .rst(rst), .lvl(lvl_a), .pulse(pulse2), .level(level2));
  level_to_pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .ACTIVE_LOW(0), .EDGE_MODE(0)) u6 (
    .clk(clk), .rst(rst), .lvl(lvl_b), .pulse(pulse6), .level(level6));

  // Behavioural model: raw samples delayed by the synchronizer depth, then a run of
  // D+1 consecutive disagreeing samples flips the accepted value.
  int unsigned p_s[3] = '{2, 2, 2};
  int unsigned p_d[3] = '{4, 4, 0};
  int unsigned p_al[3] = '{1, 1, 0};
  int unsigned p_m[3] = '{0, 2, 0};
  logic hist[3][4];
  logic m_raw[3];
  int   m_run[3];
  logic m_lev[3];
  logic m_prev[3];
  logic m_pul[3];
  bit   model_ok = 1'b0;

  task automatic model_step(input int d, input logic raw);
    logic inact;
    logic synced;
    logic r, f;
    inact = (p_al[d] != 0);
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[d][i] = inact;
      m_raw[d] = inact; m_run[d] = 0;
      m_lev[d] = 1'b0; m_prev[d] = 1'b0; m_pul[d] = 1'b0;
    end else begin
      r = m_lev[d] & ~m_prev[d];
      f = ~m_lev[d] & m_prev[d];
      m_pul[d] = (p_m[d] == 0) ? r : (p_m[d] == 1) ? f : (r | f);
      m_prev[d] = m_lev[d];
      synced = hist[d][0];
      for (int i = 0; i < int'(p_s[d]) - 1; i++) hist[d][i] = hist[d][i+1];
      hist[d][p_s[d]-1] = raw;
      if (synced != m_raw[d]) begin
        m_run[d]++;
        if (m_run[d] > int'(p_d[d])) begin
          m_raw[d] = synced;
          m_run[d] = 0;
        end
      end else begin
        m_run[d] = 0;
      end
      m_lev[d] = m_raw[d] ^ inact;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, lvl_a);
    model_step(1, lvl_a);
    model_step(2, lvl_b);
    model_ok = 1'b1;
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_pulse0", pulse0, m_pul[0]);
      check("model_level0", level0, m_lev[0]);
      check("model_pulse2", pulse2, m_pul[1]);
      check("model_level2", level2, m_lev[1]);
      check("model_pulse6", pulse6, m_pul[2]);
      check("model_level6", level6, m_lev[2]);
    end
  end

  int pc0 = 0, pc2 = 0, pc6 = 0;
  always @(negedge clk) begin
    pc0 += int'(pulse0);
    pc2 += int'(pulse2);
    pc6 += int'(pulse6);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d pulses expected %0d", name, act, exp);
    end
  endtask

  int base0, base2, base6;

  initial begin
    rst = 1'b1; lvl_a = 1'b1; lvl_b = 1'b0;
    tick(3);
    check("reset_pulse", pulse0, 1'b0);
    check("reset_level", level0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_pulse", pulse0, 1'b0);
      check("idle_level", level0, 1'b0);
    end

    // Press: level after edge 6, pulse only after edge 7.
    base0 = pc0;
    lvl_a = 1'b0;
    tick(6);
    check("press_level_e5", level0, 1'b0);
    tick(1);
    check("press_level_e6", level0, 1'b1);
    check("press_pulse_e6", pulse0, 1'b0);
    tick(1);
    check("press_pulse_e7", pulse0, 1'b1);
    tick(1);
    check("press_pulse_e8", pulse0, 1'b0);
    tick(12);
    check_count("press_once", pc0 - base0, 1);
    lvl_a = 1'b1;
    tick(15);
    check("release_level", level0, 1'b0);

    // Short glitch filtered, long enough low accepted once.
    base0 = pc0;
    lvl_a = 1'b0; tick(3); lvl_a = 1'b1; tick(15);
    check_count("glitch3", pc0 - base0, 0);
    check("glitch3_level", level0, 1'b0);
    lvl_a = 1'b0; tick(6); lvl_a = 1'b1; tick(20);
    check_count("low6", pc0 - base0, 1);

    // Both-edge mode: pulse 7 cycles after press and after release.
    base0 = pc0; base2 = pc2;
    lvl_a = 1'b0;
    tick(7);
    check("both_press_e6", pulse2, 1'b0);
    tick(1);
    check("both_press_e7", pulse2, 1'b1);
    tick(13);
    lvl_a = 1'b1;
    tick(7);
    check("both_rel_e6", pulse2, 1'b0);
    tick(1);
    check("both_rel_e7", pulse2, 1'b1);
    tick(12);
    check_count("both_two", pc2 - base2, 2);
    check_count("press_only_one", pc0 - base0, 1);

    // Reset mid-debounce with the button held: re-accepted after reset.
    base0 = pc0;
    lvl_a = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("rst_mid_pulse", pulse0, 1'b0);
    check("rst_mid_level", level0, 1'b0);
    rst = 1'b0;
    tick(7);
    check("rearm_level_e6", level0, 1'b1);
    check("rearm_pulse_e6", pulse0, 1'b0);
    tick(1);
    check("rearm_pulse_e7", pulse0, 1'b1);
    tick(10);
    check_count("rearm_once", pc0 - base0, 1);
    lvl_a = 1'b1;
    tick(15);

    // No debounce, active-high: pulse 3 cycles after rise, none on fall.
    base6 = pc6;
    lvl_b = 1'b1;
    tick(3);
    check("nodb_level_e2", level6, 1'b1);
    check("nodb_pulse_e2", pulse6, 1'b0);
    tick(1);
    check("nodb_pulse_e3", pulse6, 1'b1);
    tick(1);
    check("nodb_pulse_e4", pulse6, 1'b0);
    lvl_b = 1'b0;
    tick(10);
    check_count("nodb_fall", pc6 - base6, 1);
    check("nodb_level_low", level6, 1'b0);

    // Pseudo-random chatter, checked only against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) lvl_a = ~lvl_a;
      if ($urandom_range(0, 2) == 0) lvl_b = ~lvl_b;
      tick(1);
    end
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
